// File: rtl/axi_txn_limiter_pkg.sv
// Shared AXI utilities: limiter FSM states, default AXI request/response structs
// and a small ATOP decode helper.
package axi_txn_limiter_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DRAINED = 2'd2
    } lim_state_e;

    localparam int unsigned IdW   = 4;
    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 32;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [AddrW-1:0] addr;
        logic [7:0]       len;
        logic [5:0]       atop;
    } axi_aw_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [AddrW-1:0] addr;
        logic [7:0]       len;
    } axi_ar_t;

    typedef struct packed {
        logic [DataW-1:0]   data;
        logic [DataW/8-1:0] strb;
        logic               last;
    } axi_w_t;

    typedef struct packed {
        logic [IdW-1:0] id;
        logic [1:0]     resp;
    } axi_b_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [DataW-1:0] data;
        logic [1:0]       resp;
        logic             last;
    } axi_r_t;

    typedef struct packed {
        axi_aw_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ar_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        axi_b_t b;
        logic   b_valid;
        axi_r_t r;
        logic   r_valid;
    } axi_resp_t;

    // Atomics with atop[5] set also return read data, so they occupy a read slot.
    function automatic logic is_atop_rd(input logic [5:0] atop);
        return atop[5];
    endfunction

endpackage

// File: rtl/axi_txn_counter.sv
// Saturation-free up/down outstanding-transaction counter with a "full" flag.
// Increment may be 0..2 per cycle, decrement 0..1.
module axi_txn_counter
    import axi_txn_limiter_pkg::*;
#(
    parameter int unsigned MaxCnt = 8
) (
    input  logic                         clk_i,
    input  logic                         arst_ni,
    input  logic [1:0]                   i_inc,
    input  logic                         i_dec,
    output logic [$clog2(MaxCnt+1)-1:0]  o_cnt,
    output logic                         o_full
);
    localparam int unsigned CntW = $clog2(MaxCnt+1);

    logic [CntW-1:0] r_cnt;
    logic [CntW:0]   w_cnt_nxt;

    assign w_cnt_nxt = {1'b0, r_cnt} + (CntW+1)'(i_inc) - (CntW+1)'(i_dec);

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) r_cnt <= '0;
        else          r_cnt <= w_cnt_nxt[CntW-1:0];
    end

    assign o_cnt  = r_cnt;
    assign o_full = (r_cnt >= CntW'(MaxCnt));

`ifndef SYNTHESIS
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!arst_ni)
        (int'(r_cnt) + int'(i_inc) >= int'(i_dec)));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!arst_ni)
        (int'(r_cnt) + int'(i_inc) - int'(i_dec) <= int'(MaxCnt)));
`endif

endmodule

// File: rtl/axi_txn_limiter.sv
// Caps outstanding AXI write/read bursts by gating AW/AR; W/B/R pass straight
// through. A drain request stops new AW/AR and reports idle once all retire.
module axi_txn_limiter
    import axi_txn_limiter_pkg::*;
#(
    parameter type         req_t     = axi_req_t,
    parameter type         resp_t    = axi_resp_t,
    parameter int unsigned MaxWrTxns = 8,
    parameter int unsigned MaxRdTxns = 8
) (
    input  logic                             clk_i,
    input  logic                             arst_ni,
    input  req_t                             slv_req_i,
    output resp_t                            slv_resp_o,
    output req_t                             mst_req_o,
    input  resp_t                            mst_resp_i,
    input  logic                             drain_i,
    output logic                             idle_o,
    output logic [$clog2(MaxWrTxns+1)-1:0]   wr_cnt_o,
    output logic [$clog2(MaxRdTxns+1)-1:0]   rd_cnt_o
);
    lim_state_e r_state, w_state_nxt;
    logic       r_aw_lock, r_ar_lock, r_idle;
    logic       w_aw_allow, w_ar_allow, w_atop_rd;
    logic       w_aw_hs, w_ar_hs, w_b_hs, w_r_last_hs;
    logic       w_wr_full, w_rd_full;
    logic [1:0] w_wr_inc, w_rd_inc;

    always_comb begin
        mst_req_o           = slv_req_i;
        mst_req_o.aw_valid  = slv_req_i.aw_valid & w_aw_allow;
        mst_req_o.ar_valid  = slv_req_i.ar_valid & w_ar_allow;
        slv_resp_o          = mst_resp_i;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & w_aw_allow;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & w_ar_allow;
    end

    assign w_atop_rd   = is_atop_rd(slv_req_i.aw.atop);
    assign w_aw_hs     = mst_req_o.aw_valid & mst_resp_i.aw_ready;
    assign w_ar_hs     = mst_req_o.ar_valid & mst_resp_i.ar_ready;
    assign w_b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;
    assign w_r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
    assign w_wr_inc    = {1'b0, w_aw_hs};
    assign w_rd_inc    = {1'b0, w_ar_hs} + {1'b0, w_aw_hs & w_atop_rd};

    // Once a valid reaches the master port it must stay up until accepted,
    // even if the count fills or a drain starts in the meantime.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_aw_lock <= 1'b0;
            r_ar_lock <= 1'b0;
        end else begin
            if (w_aw_hs)                 r_aw_lock <= 1'b0;
            else if (mst_req_o.aw_valid) r_aw_lock <= 1'b1;
            if (w_ar_hs)                 r_ar_lock <= 1'b0;
            else if (mst_req_o.ar_valid) r_ar_lock <= 1'b1;
        end
    end

    axi_txn_counter #(.MaxCnt(MaxWrTxns)) u_wr_cnt (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .i_inc   (w_wr_inc),
        .i_dec   (w_b_hs),
        .o_cnt   (wr_cnt_o),
        .o_full  (w_wr_full)
    );

    axi_txn_counter #(.MaxCnt(MaxRdTxns)) u_rd_cnt (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .i_inc   (w_rd_inc),
        .i_dec   (w_r_last_hs),
        .o_cnt   (rd_cnt_o),
        .o_full  (w_rd_full)
    );

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state <= ST_RUN;
            r_idle  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idle  <= (w_state_nxt == ST_DRAINED);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:     if (drain_i) w_state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (!drain_i)
                    w_state_nxt = ST_RUN;
                else if (wr_cnt_o == '0 && rd_cnt_o == '0 && !r_aw_lock && !r_ar_lock)
                    w_state_nxt = ST_DRAINED;
            end
            ST_DRAINED: if (!drain_i) w_state_nxt = ST_RUN;
            default:    w_state_nxt = ST_RUN;
        endcase
    end

    // Reset is folded into the allow terms so AW/AR stay quiet while held in reset.
    always_comb begin
        w_aw_allow = arst_ni & (r_aw_lock |
                     ((r_state == ST_RUN) & !w_wr_full & (!w_atop_rd | !w_rd_full)));
        w_ar_allow = arst_ni & (r_ar_lock | ((r_state == ST_RUN) & !w_rd_full));
        idle_o     = r_idle;
    end

`ifndef SYNTHESIS
    a_aw_stable: assert property (@(posedge clk_i) disable iff (!arst_ni)
        (mst_req_o.aw_valid && !mst_resp_i.aw_ready) |=> mst_req_o.aw_valid);
    a_ar_stable: assert property (@(posedge clk_i) disable iff (!arst_ni)
        (mst_req_o.ar_valid && !mst_resp_i.ar_ready) |=> mst_req_o.ar_valid);
`endif

endmodule

// File: tb/tb_axi_txn_limiter.sv
// Directed bench for axi_txn_limiter: limit, atomics, drain/resume and reset.
module tb_axi_txn_limiter;
    import axi_txn_limiter_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    logic      drain, idle;
    axi_req_t  slv_req, mst_req;
    axi_resp_t slv_resp, mst_resp;
    logic [1:0] wr_cnt, rd_cnt;

    logic      b_drain, b_idle;
    axi_req_t  b_slv_req, b_mst_req;
    axi_resp_t b_slv_resp, b_mst_resp;
    logic [2:0] b_wr_cnt, b_rd_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    axi_txn_limiter #(
        .req_t(axi_req_t), .resp_t(axi_resp_t), .MaxWrTxns(2), .MaxRdTxns(2)
    ) dut (
        .clk_i(clk), .arst_ni(rst_n),
        .slv_req_i(slv_req), .slv_resp_o(slv_resp),
        .mst_req_o(mst_req), .mst_resp_i(mst_resp),
        .drain_i(drain), .idle_o(idle),
        .wr_cnt_o(wr_cnt), .rd_cnt_o(rd_cnt)
    );

    axi_txn_limiter #(
        .req_t(axi_req_t), .resp_t(axi_resp_t), .MaxWrTxns(4), .MaxRdTxns(4)
    ) dut_b (
        .clk_i(clk), .arst_ni(rst_n),
        .slv_req_i(b_slv_req), .slv_resp_o(b_slv_resp),
        .mst_req_o(b_mst_req), .mst_resp_i(b_mst_resp),
        .drain_i(b_drain), .idle_o(b_idle),
        .wr_cnt_o(b_wr_cnt), .rd_cnt_o(b_rd_cnt)
    );

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; drain = 1'b0; b_drain = 1'b0;
        slv_req = '0; mst_resp = '0; b_slv_req = '0; b_mst_resp = '0;
        slv_req.aw_valid = 1'b1;
        slv_req.w_valid  = 1'b1;
        slv_req.w.data   = 32'hA5A5_0001;
        mst_resp.aw_ready = 1'b1;
        #2;
        n_cmp++; if (mst_req.aw_valid !== 1'b0) begin n_bad++; $display("FAIL rst_aw_valid: got %b want 0", mst_req.aw_valid); end
        n_cmp++; if (mst_req.w_valid !== 1'b1) begin n_bad++; $display("FAIL rst_w_pass: got %b want 1", mst_req.w_valid); end
        n_cmp++; if (mst_req.w.data !== 32'hA5A5_0001) begin n_bad++; $display("FAIL rst_w_data: got %h want a5a50001", mst_req.w.data); end
        n_cmp++; if (wr_cnt !== 2'd0 || rd_cnt !== 2'd0) begin n_bad++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", wr_cnt, rd_cnt); end
        n_cmp++; if (idle !== 1'b0) begin n_bad++; $display("FAIL rst_idle: got %b want 0", idle); end
        slv_req = '0; mst_resp = '0;
        @(negedge clk); rst_n = 1'b1;
        slv_req.b_ready = 1'b1; slv_req.r_ready = 1'b1;
        mst_resp.aw_ready = 1'b1; mst_resp.ar_ready = 1'b1;
    endtask

    task automatic test_passthrough();
        nxt();
        slv_req.w_valid = 1'b1; slv_req.w.data = 32'h1234_5678; slv_req.w.strb = 4'hC; slv_req.w.last = 1'b1;
        mst_resp.w_ready = 1'b1;
        mst_resp.b = '{id: 4'h3, resp: 2'b10};
        mst_resp.r = '{id: 4'h5, data: 32'hDEAD_BEEF, resp: 2'b01, last: 1'b0};
        #1;
        n_cmp++; if (mst_req.w !== slv_req.w) begin n_bad++; $display("FAIL pass_w: got %h want %h", mst_req.w, slv_req.w); end
        n_cmp++; if (slv_resp.w_ready !== 1'b1) begin n_bad++; $display("FAIL pass_wready: got %b want 1", slv_resp.w_ready); end
        n_cmp++; if (slv_resp.b !== mst_resp.b) begin n_bad++; $display("FAIL pass_b: got %h want %h", slv_resp.b, mst_resp.b); end
        n_cmp++; if (slv_resp.r.data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL pass_r: got %h want deadbeef", slv_resp.r.data); end
        slv_req.w = '0; slv_req.w_valid = 1'b0; mst_resp.w_ready = 1'b0;
    endtask

    task automatic test_wr_limit();
        nxt(); slv_req.aw_valid = 1'b1; slv_req.aw.addr = 32'h100;
        mid();
        n_cmp++; if (slv_resp.aw_ready !== 1'b1 || mst_req.aw.addr !== 32'h100) begin n_bad++; $display("FAIL wl_hs1: got rdy=%b addr=%h want 1/100", slv_resp.aw_ready, mst_req.aw.addr); end
        nxt(); slv_req.aw.addr = 32'h200;
        mid();
        n_cmp++; if (slv_resp.aw_ready !== 1'b1 || wr_cnt !== 2'd1) begin n_bad++; $display("FAIL wl_hs2: got rdy=%b cnt=%0d want 1/1", slv_resp.aw_ready, wr_cnt); end
        nxt(); slv_req.aw.addr = 32'h300;
        mid();
        n_cmp++; if (slv_resp.aw_ready !== 1'b0 || mst_req.aw_valid !== 1'b0 || wr_cnt !== 2'd2) begin n_bad++; $display("FAIL wl_stall: got rdy=%b vld=%b cnt=%0d want 0/0/2", slv_resp.aw_ready, mst_req.aw_valid, wr_cnt); end
        nxt();
        mid();
        n_cmp++; if (slv_resp.aw_ready !== 1'b0) begin n_bad++; $display("FAIL wl_stall2: got %b want 0", slv_resp.aw_ready); end
        nxt(); mst_resp.b_valid = 1'b1;
        mid();
        n_cmp++; if (slv_resp.aw_ready !== 1'b0) begin n_bad++; $display("FAIL wl_bcycle: got %b want 0", slv_resp.aw_ready); end
        nxt(); mst_resp.b_valid = 1'b0;
        mid();
        n_cmp++; if (slv_resp.aw_ready !== 1'b1 || wr_cnt !== 2'd1) begin n_bad++; $display("FAIL wl_resume: got rdy=%b cnt=%0d want 1/1", slv_resp.aw_ready, wr_cnt); end
        nxt(); slv_req.aw_valid = 1'b0;
        mid();
        n_cmp++; if (wr_cnt !== 2'd2) begin n_bad++; $display("FAIL wl_cnt2: got %0d want 2", wr_cnt); end
        nxt(); mst_resp.b_valid = 1'b1;
        nxt(); nxt(); mst_resp.b_valid = 1'b0;
        mid();
        n_cmp++; if (wr_cnt !== 2'd0) begin n_bad++; $display("FAIL wl_clean: got %0d want 0", wr_cnt); end
    endtask

    task automatic test_rd_same_cycle();
        nxt(); slv_req.ar_valid = 1'b1; slv_req.ar.addr = 32'h800;
        mid();
        n_cmp++; if (slv_resp.ar_ready !== 1'b1) begin n_bad++; $display("FAIL rs_ar1: got %b want 1", slv_resp.ar_ready); end
        nxt(); mst_resp.r_valid = 1'b1; mst_resp.r.last = 1'b1;
        mid();
        n_cmp++; if (slv_resp.ar_ready !== 1'b1 || rd_cnt !== 2'd1) begin n_bad++; $display("FAIL rs_same: got rdy=%b cnt=%0d want 1/1", slv_resp.ar_ready, rd_cnt); end
        nxt(); mst_resp.r_valid = 1'b0;
        mid();
        n_cmp++; if (rd_cnt !== 2'd1 || slv_resp.ar_ready !== 1'b1) begin n_bad++; $display("FAIL rs_after: got cnt=%0d rdy=%b want 1/1", rd_cnt, slv_resp.ar_ready); end
        nxt(); slv_req.ar_valid = 1'b0;
        mid();
        n_cmp++; if (rd_cnt !== 2'd2) begin n_bad++; $display("FAIL rs_cnt2: got %0d want 2", rd_cnt); end
    endtask

    task automatic test_atop();
        nxt(); slv_req.aw_valid = 1'b1; slv_req.aw.atop = 6'b100000; slv_req.aw.addr = 32'h900;
        mid();
        n_cmp++; if (slv_resp.aw_ready !== 1'b0 || mst_req.aw_valid !== 1'b0) begin n_bad++; $display("FAIL at_stall: got rdy=%b vld=%b want 0/0", slv_resp.aw_ready, mst_req.aw_valid); end
        nxt(); mst_resp.r_valid = 1'b1; mst_resp.r.last = 1'b1;
        mid();
        n_cmp++; if (slv_resp.aw_ready !== 1'b0) begin n_bad++; $display("FAIL at_rcycle: got %b want 0", slv_resp.aw_ready); end
        nxt(); mst_resp.r_valid = 1'b0;
        mid();
        n_cmp++; if (slv_resp.aw_ready !== 1'b1 || wr_cnt !== 2'd0 || rd_cnt !== 2'd1) begin n_bad++; $display("FAIL at_accept: got rdy=%b wr=%0d rd=%0d want 1/0/1", slv_resp.aw_ready, wr_cnt, rd_cnt); end
        nxt(); slv_req.aw_valid = 1'b0; slv_req.aw.atop = 6'b0;
        mid();
        n_cmp++; if (wr_cnt !== 2'd1 || rd_cnt !== 2'd2) begin n_bad++; $display("FAIL at_cnts: got wr=%0d rd=%0d want 1/2", wr_cnt, rd_cnt); end
        nxt(); mst_resp.b_valid = 1'b1; mst_resp.r_valid = 1'b1;
        nxt(); mst_resp.b_valid = 1'b0;
        nxt(); mst_resp.r_valid = 1'b0;
        mid();
        n_cmp++; if (wr_cnt !== 2'd0 || rd_cnt !== 2'd0) begin n_bad++; $display("FAIL at_clean: got wr=%0d rd=%0d want 0/0", wr_cnt, rd_cnt); end
    endtask

    task automatic test_drain();
        nxt(); mst_resp.aw_ready = 1'b0; slv_req.aw_valid = 1'b1; slv_req.aw.addr = 32'h400;
        mid();
        n_cmp++; if (mst_req.aw_valid !== 1'b1) begin n_bad++; $display("FAIL dr_present: got %b want 1", mst_req.aw_valid); end
        nxt(); drain = 1'b1;
        nxt(); slv_req.ar_valid = 1'b1;
        mid();
        n_cmp++; if (mst_req.aw_valid !== 1'b1) begin n_bad++; $display("FAIL dr_hold: got %b want 1", mst_req.aw_valid); end
        n_cmp++; if (mst_req.ar_valid !== 1'b0 || slv_resp.ar_ready !== 1'b0) begin n_bad++; $display("FAIL dr_ar_block: got vld=%b rdy=%b want 0/0", mst_req.ar_valid, slv_resp.ar_ready); end
        nxt(); mst_resp.aw_ready = 1'b1; slv_req.ar_valid = 1'b0;
        mid();
        n_cmp++; if (slv_resp.aw_ready !== 1'b1) begin n_bad++; $display("FAIL dr_hs: got %b want 1", slv_resp.aw_ready); end
        nxt(); slv_req.aw.addr = 32'h500;
        mid();
        n_cmp++; if (mst_req.aw_valid !== 1'b0 || wr_cnt !== 2'd1) begin n_bad++; $display("FAIL dr_aw_block: got vld=%b cnt=%0d want 0/1", mst_req.aw_valid, wr_cnt); end
        nxt(); slv_req.aw_valid = 1'b0; mst_resp.b_valid = 1'b1;
        mid();
        n_cmp++; if (idle !== 1'b0) begin n_bad++; $display("FAIL dr_idle_b: got %b want 0", idle); end
        nxt(); mst_resp.b_valid = 1'b0;
        mid();
        n_cmp++; if (idle !== 1'b0 || wr_cnt !== 2'd0) begin n_bad++; $display("FAIL dr_idle_early: got idle=%b cnt=%0d want 0/0", idle, wr_cnt); end
        nxt();
        mid();
        n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL dr_idle: got %b want 1", idle); end
    endtask

    task automatic test_resume();
        nxt(); drain = 1'b0;
        mid();
        n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL rm_hold: got %b want 1", idle); end
        nxt(); slv_req.ar_valid = 1'b1;
        mid();
        n_cmp++; if (idle !== 1'b0 || slv_resp.ar_ready !== 1'b1) begin n_bad++; $display("FAIL rm_run: got idle=%b rdy=%b want 0/1", idle, slv_resp.ar_ready); end
        nxt(); slv_req.ar_valid = 1'b0; mst_resp.r_valid = 1'b1; mst_resp.r.last = 1'b1;
        mid();
        n_cmp++; if (rd_cnt !== 2'd1) begin n_bad++; $display("FAIL rm_cnt: got %0d want 1", rd_cnt); end
        nxt(); mst_resp.r_valid = 1'b0;
        mid();
        n_cmp++; if (rd_cnt !== 2'd0) begin n_bad++; $display("FAIL rm_clean: got %0d want 0", rd_cnt); end
    endtask

    task automatic test_reset_midburst();
        nxt(); b_mst_resp.aw_ready = 1'b1; b_mst_resp.ar_ready = 1'b1;
        b_slv_req.aw_valid = 1'b1; b_slv_req.ar_valid = 1'b1;
        nxt(); b_slv_req.ar_valid = 1'b0;
        nxt(); nxt(); b_slv_req.aw_valid = 1'b0;
        mid();
        n_cmp++; if (b_wr_cnt !== 3'd3 || b_rd_cnt !== 3'd1) begin n_bad++; $display("FAIL mr_pre: got wr=%0d rd=%0d want 3/1", b_wr_cnt, b_rd_cnt); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (b_wr_cnt !== 3'd0 || b_rd_cnt !== 3'd0) begin n_bad++; $display("FAIL mr_async: got wr=%0d rd=%0d want 0/0", b_wr_cnt, b_rd_cnt); end
        b_slv_req = '0; b_mst_resp = '0;
        @(negedge clk); rst_n = 1'b1;
        nxt(); b_mst_resp.aw_ready = 1'b1; b_slv_req.aw_valid = 1'b1;
        mid();
        n_cmp++; if (b_mst_req.aw_valid !== 1'b1 || b_idle !== 1'b0) begin n_bad++; $display("FAIL mr_run: got vld=%b idle=%b want 1/0", b_mst_req.aw_valid, b_idle); end
        nxt(); b_slv_req.aw_valid = 1'b0;
        mid();
        n_cmp++; if (b_wr_cnt !== 3'd1) begin n_bad++; $display("FAIL mr_cnt: got %0d want 1", b_wr_cnt); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_wr_limit();
        test_rd_same_cycle();
        test_atop();
        test_drain();
        test_resume();
        test_reset_midburst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
